// File: rtl/pci_pkg.sv
// rtl/pci_pkg.sv - shared command codes, FSM states and active-low levels for the PCI target
package pci_pkg;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    localparam logic ASSERTED   = 1'b0;
    localparam logic DEASSERTED = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        RTURN = 3'd2,
        RDATA = 3'd3,
        END   = 3'd4,
        BUSY  = 3'd5
    } pci_state_t;

endpackage

// File: rtl/pci_addr_decode.sv
// rtl/pci_addr_decode.sv - combinational address/command decode for the target window
//
// Ports:
//   AD_in     in  32  address as sampled in the address phase
//   C_BE      in  4   bus command in the address phase
//   hit       out 1   supported memory command inside the window
//   is_write  out 1   command is a memory write
//   start_ptr out 4   word index of AD_in within the window
module pci_addr_decode
    import pci_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          DEPTH     = 10
) (
    input  logic [31:0] AD_in,
    input  logic [3:0]  C_BE,
    output logic        hit,
    output logic        is_write,
    output logic [3:0]  start_ptr
);

    localparam logic [31:0] LIMIT = BASE_ADDR + 32'(4 * DEPTH);

    logic in_range;
    logic cmd_ok;

    assign in_range = (AD_in >= BASE_ADDR) && (AD_in < LIMIT);
    assign cmd_ok   = (C_BE == CMD_MEM_WRITE) || (C_BE == CMD_MEM_READ);
    assign hit      = in_range && cmd_ok;
    assign is_write = (C_BE == CMD_MEM_WRITE);

    // The window is 64-byte aligned and at most 16 words, so inside the window
    // the word offset is simply the address bits [5:2].
    assign start_ptr = AD_in[5:2];

endmodule

// File: rtl/pci_target_ctrl.sv
// rtl/pci_target_ctrl.sv - PCI target controller driving DEVSEL#/TRDY# and the word memory port
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   FRAME, IRDY, C_BE       PCI master controls (active low)
//   AD_in / AD_out / AD_oe  sampled AD, read data toward the pads, pad enable
//   DEVSEL, TRDY            PCI target responses (active low)
//   mem_we, mem_addr        write strobe and shared word pointer
//   mem_wdata, mem_be       write data and active-high byte enables
//   mem_rdata               combinational memory read of mem_addr
module pci_target_ctrl
    import pci_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          DEPTH     = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        FRAME,
    input  logic        IRDY,
    input  logic [3:0]  C_BE,
    input  logic [31:0] AD_in,
    output logic [31:0] AD_out,
    output logic        AD_oe,
    output logic        DEVSEL,
    output logic        TRDY,
    output logic        mem_we,
    output logic [3:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata
);

    pci_state_t state, state_nxt;
    logic       frame_q, irdy_q;
    logic [3:0] ptr;

    logic       hit, is_write;
    logic [3:0] start_ptr;
    logic       addr_phase, can_decode, in_data, xfer;

    pci_addr_decode #(
        .BASE_ADDR (BASE_ADDR),
        .DEPTH     (DEPTH)
    ) u_decode (
        .AD_in     (AD_in),
        .C_BE      (C_BE),
        .hit       (hit),
        .is_write  (is_write),
        .start_ptr (start_ptr)
    );

    // A new transaction starts only when the bus was idle on the previous edge.
    assign addr_phase = (FRAME == ASSERTED) && (frame_q == DEASSERTED) && (irdy_q == DEASSERTED);
    assign can_decode = (state == IDLE) || (state == END);
    assign in_data    = (state == WDATA) || (state == RDATA);
    // TRDY is always asserted in the data states, so IRDY alone completes a phase.
    assign xfer       = in_data && (IRDY == ASSERTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            frame_q <= DEASSERTED;
            irdy_q  <= DEASSERTED;
            ptr     <= 4'd0;
        end else begin
            state   <= state_nxt;
            frame_q <= FRAME;
            irdy_q  <= IRDY;
            if (can_decode && addr_phase && hit) begin
                ptr <= start_ptr;
            end else if (xfer) begin
                ptr <= (ptr == 4'(DEPTH - 1)) ? 4'd0 : ptr + 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, END: begin
                if (addr_phase) begin
                    if (!hit)          state_nxt = BUSY;
                    else if (is_write) state_nxt = WDATA;
                    else               state_nxt = RTURN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WDATA, RDATA: begin
                if (xfer && FRAME == DEASSERTED)
                    state_nxt = END;
                else if (FRAME == DEASSERTED && IRDY == DEASSERTED)
                    state_nxt = END;
            end
            RTURN: state_nxt = RDATA;
            BUSY: begin
                if (FRAME == DEASSERTED && IRDY == DEASSERTED) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        DEVSEL = DEASSERTED;
        TRDY   = DEASSERTED;
        AD_oe  = 1'b0;
        AD_out = 32'd0;
        mem_we = 1'b0;
        case (state)
            WDATA: begin
                DEVSEL = ASSERTED;
                TRDY   = ASSERTED;
                mem_we = (IRDY == ASSERTED);
            end
            RTURN: begin
                DEVSEL = ASSERTED;
            end
            RDATA: begin
                DEVSEL = ASSERTED;
                TRDY   = ASSERTED;
                AD_oe  = 1'b1;
                AD_out = mem_rdata;
            end
            default: ;
        endcase
    end

    assign mem_addr  = ptr;
    assign mem_wdata = AD_in;
    assign mem_be    = ~C_BE;

endmodule

// File: tb/tb_pci_target_ctrl.sv
// tb/tb_pci_target_ctrl.sv - scoreboard testbench for pci_target_ctrl
module tb_pci_target_ctrl;
    import pci_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        FRAME, IRDY;
    logic [3:0]  C_BE;
    logic [31:0] AD_in, AD_out, mem_wdata, mem_rdata;
    logic        AD_oe, DEVSEL, TRDY, mem_we;
    logic [3:0]  mem_addr, mem_be;

    always #5 clk = ~clk;

    pci_target_ctrl #(.BASE_ADDR(32'h0000_1000), .DEPTH(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .FRAME     (FRAME),
        .IRDY      (IRDY),
        .C_BE      (C_BE),
        .AD_in     (AD_in),
        .AD_out    (AD_out),
        .AD_oe     (AD_oe),
        .DEVSEL    (DEVSEL),
        .TRDY      (TRDY),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata)
    );

    logic [31:0] tb_mem [16];
    logic        mem_init;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int k = 0; k < 16; k++) tb_mem[k] <= 32'd0;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) tb_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end
    assign mem_rdata = tb_mem[mem_addr];

    int tests = 0;
    int fails = 0;

    logic [39:0] wq [$];
    logic [31:0] rq [$];
    logic [39:0] wexp;
    logic [31:0] rexp;

    logic [31:0] wd [4];
    logic [3:0]  wa [4];
    logic [31:0] rd [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            if (wq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
            end else begin
                wexp = wq.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(wexp[39:36]));
                chk("wr_data", mem_wdata, wexp[35:4]);
                chk("wr_be", 32'(mem_be), 32'(wexp[3:0]));
            end
        end
        if (rst_n === 1'b1 && AD_oe === 1'b1 && TRDY === ASSERTED && IRDY === ASSERTED) begin
            if (rq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_read: got %h expected no read", AD_out);
            end else begin
                rexp = rq.pop_front();
                chk("rd_data", AD_out, rexp);
            end
        end
    end

    task automatic do_write(input logic [31:0] addr, input int n, input logic [3:0] cbe,
                            input int wait_at, input int nwait);
        FRAME = 1'b0; IRDY = 1'b1; AD_in = addr; C_BE = CMD_MEM_WRITE;
        step();
        chk("w_devsel", 32'(DEVSEL), 32'(ASSERTED));
        chk("w_trdy", 32'(TRDY), 32'(ASSERTED));
        for (int i = 0; i < n; i++) begin
            if (i == wait_at) begin
                for (int w = 0; w < nwait; w++) begin
                    FRAME = 1'b0; IRDY = 1'b1; AD_in = 32'h5555_AAAA; C_BE = cbe;
                    step();
                    chk("wait_addr", 32'(mem_addr), 32'(wa[i]));
                    chk("wait_trdy", 32'(TRDY), 32'(ASSERTED));
                end
            end
            FRAME = (i == n - 1); IRDY = 1'b0; AD_in = wd[i]; C_BE = cbe;
            wq.push_back({wa[i], wd[i], ~cbe});
            step();
        end
        chk("w_end_devsel", 32'(DEVSEL), 32'(DEASSERTED));
        chk("w_end_trdy", 32'(TRDY), 32'(DEASSERTED));
        FRAME = 1'b1; IRDY = 1'b1; AD_in = 32'd0; C_BE = 4'd0;
        step();
        chk("w_idle_devsel", 32'(DEVSEL), 32'(DEASSERTED));
    endtask

    task automatic do_read(input logic [31:0] addr, input int n);
        FRAME = 1'b0; IRDY = 1'b1; AD_in = addr; C_BE = CMD_MEM_READ;
        step();
        chk("rt_devsel", 32'(DEVSEL), 32'(ASSERTED));
        chk("rt_trdy", 32'(TRDY), 32'(DEASSERTED));
        chk("rt_oe", 32'(AD_oe), 32'd0);
        for (int i = 0; i < n; i++) begin
            FRAME = (i == n - 1); IRDY = 1'b0; AD_in = 32'd0; C_BE = 4'd0;
            rq.push_back(rd[i]);
            if (i == 0) begin
                step();
                chk("rd_trdy", 32'(TRDY), 32'(ASSERTED));
                chk("rd_oe", 32'(AD_oe), 32'd1);
                chk("rd_first", AD_out, rd[0]);
            end
            step();
        end
        chk("r_end_oe", 32'(AD_oe), 32'd0);
        chk("r_end_devsel", 32'(DEVSEL), 32'(DEASSERTED));
        FRAME = 1'b1; IRDY = 1'b1;
        step();
    endtask

    logic [31:0] miss_ad  [4];
    logic [3:0]  miss_cbe [4];

    initial begin
        rst_n = 1'b0; mem_init = 1'b0;
        FRAME = 1'b1; IRDY = 1'b1; C_BE = 4'd0; AD_in = 32'd0;
        step();
        step();
        chk("rst_devsel", 32'(DEVSEL), 32'(DEASSERTED));
        chk("rst_trdy", 32'(TRDY), 32'(DEASSERTED));
        chk("rst_oe", 32'(AD_oe), 32'd0);
        chk("rst_adout", AD_out, 32'd0);
        chk("rst_ptr", 32'(mem_addr), 32'd0);
        rst_n = 1'b1; mem_init = 1'b1;
        step();

        // single write to word 2
        wd[0] = 32'hDEAD_BEEF; wa[0] = 4'd2;
        do_write(32'h0000_1008, 1, 4'b0000, -1, 0);

        // burst write wrapping past the last word, upper two bytes only
        wd[0] = 32'hA000_0000; wd[1] = 32'hA000_0001; wd[2] = 32'hA000_0002; wd[3] = 32'hA000_0003;
        wa[0] = 4'd8; wa[1] = 4'd9; wa[2] = 4'd0; wa[3] = 4'd1;
        do_write(32'h0000_1020, 4, 4'b0011, -1, 0);

        // burst write with two wait states before the second phase
        wd[0] = 32'h1234_5678; wd[1] = 32'hCAFE_F00D; wd[2] = 32'h0BAD_C0DE;
        wa[0] = 4'd1; wa[1] = 4'd2; wa[2] = 4'd3;
        do_write(32'h0000_1004, 3, 4'b0000, 1, 2);

        // single read, then a two-word read burst
        rd[0] = 32'h1234_5678;
        do_read(32'h0000_1004, 1);
        rd[0] = 32'h1234_5678; rd[1] = 32'hCAFE_F00D;
        do_read(32'h0000_1004, 2);

        // misses: outside window, unsupported command, one past the end, below base
        miss_ad[0] = 32'h0000_2000; miss_cbe[0] = CMD_MEM_WRITE;
        miss_ad[1] = 32'h0000_1000; miss_cbe[1] = 4'b0010;
        miss_ad[2] = 32'h0000_1028; miss_cbe[2] = CMD_MEM_WRITE;
        miss_ad[3] = 32'h0000_0FFC; miss_cbe[3] = CMD_MEM_READ;
        for (int m = 0; m < 4; m++) begin
            FRAME = 1'b0; IRDY = 1'b1; AD_in = miss_ad[m]; C_BE = miss_cbe[m];
            step();
            chk("miss_devsel_a", 32'(DEVSEL), 32'(DEASSERTED));
            FRAME = 1'b0; IRDY = 1'b0; AD_in = 32'hFFFF_0000; C_BE = 4'd0;
            step();
            chk("miss_devsel_d", 32'(DEVSEL), 32'(DEASSERTED));
            chk("miss_trdy", 32'(TRDY), 32'(DEASSERTED));
            FRAME = 1'b1; IRDY = 1'b0;
            step();
            chk("miss_devsel_l", 32'(DEVSEL), 32'(DEASSERTED));
            FRAME = 1'b1; IRDY = 1'b1;
            step();
        end

        // last word of the window is a hit and proves BUSY returned to IDLE
        wd[0] = 32'h9999_0009; wa[0] = 4'd9;
        do_write(32'h0000_1024, 1, 4'b0000, -1, 0);

        // reset in the middle of a write data phase
        FRAME = 1'b0; IRDY = 1'b1; AD_in = 32'h0000_1010; C_BE = CMD_MEM_WRITE;
        step();
        chk("rst_mid_devsel_pre", 32'(DEVSEL), 32'(ASSERTED));
        FRAME = 1'b0; IRDY = 1'b0; AD_in = 32'h0BAD_0BAD; C_BE = 4'd0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_devsel", 32'(DEVSEL), 32'(DEASSERTED));
        chk("rst_mid_trdy", 32'(TRDY), 32'(DEASSERTED));
        chk("rst_mid_oe", 32'(AD_oe), 32'd0);
        chk("rst_mid_we", 32'(mem_we), 32'd0);
        step();
        FRAME = 1'b1; IRDY = 1'b1;
        rst_n = 1'b1;
        step();
        chk("rst_rel_ptr", 32'(mem_addr), 32'd0);
        chk("rst_rel_devsel", 32'(DEVSEL), 32'(DEASSERTED));
        chk("rst_no_write", tb_mem[4], 32'd0);
        chk("mem_w9", tb_mem[9], 32'h9999_0009);
        chk("mem_w8", tb_mem[8], 32'hA000_0000);

        step();
        chk("wq_empty", 32'(wq.size()), 32'd0);
        chk("rq_empty", 32'(rq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pci_target_ctrl.md
Name: pci_target_ctrl

Overview:
- PCI target-side bus controller sitting directly upstream of the device word memory.
- Detects address phases, decodes command and address, and asserts DEVSEL#/TRDY#.
- Generates the per-data-phase write strobe, word pointer, data and byte enables that the memory consumes.
- Also sources read data onto AD for memory-read bursts, with the required turnaround cycles.

Parameters:
BASE_ADDR  32'h0000_1000  byte base address of the target window; low 6 bits are zero
DEPTH      10             number of 32-bit words in the window; legal range 1..16

Ports:
clk        in   1   bus clock; all state changes on rising edge
rst_n      in   1   asynchronous, active-low reset
FRAME      in   1   PCI FRAME#, active low
IRDY       in   1   PCI IRDY#, active low
C_BE       in   4   PCI C/BE#: command in the address phase, active-low byte enables in data phases
AD_in      in   32  PCI AD as sampled from the bus
AD_out     out  32  read data driven toward the AD pads
AD_oe      out  1   AD output enable, 1 = drive
DEVSEL     out  1   PCI DEVSEL#, active low
TRDY       out  1   PCI TRDY#, active low
mem_we     out  1   write strobe for the current data phase, combinational
mem_addr   out  4   current word pointer, shared by read and write
mem_wdata  out  32  write data, equal to AD_in
mem_be     out  4   active-high byte enables, equal to ~C_BE
mem_rdata  in   32  combinational read of mem_addr

Behaviour:
- Reset (async, rst_n=0): state IDLE, DEVSEL=1, TRDY=1, AD_oe=0, AD_out=0, pointer=0, frame_q=1, irdy_q=1. Asserting reset mid-burst aborts the burst immediately with no memory write.
- Address phase: FRAME=0 at an edge while frame_q=1 and irdy_q=1 (bus idle on the previous edge). Recognised only in IDLE or END.
- Hit test: cmd=C_BE, which is 4'b0111 (mem write) or 4'b0110 (mem read), AND BASE_ADDR <= AD_in < BASE_ADDR+4*DEPTH.
  - On hit, latch the command and load pointer = (AD_in-BASE_ADDR)>>2. AD_in[1:0] is ignored.
  - On miss or unsupported command, go to BUSY.
- States:
  - IDLE: all outputs deasserted.
  - WDATA: DEVSEL=0, TRDY=0. Entered the edge after a write hit, so DEVSEL and TRDY assert in the cycle after the address phase.
  - RTURN: DEVSEL=0, TRDY=1, AD_oe=0. Entered after a read hit; lasts exactly one cycle, then RDATA.
  - RDATA: DEVSEL=0, TRDY=0, AD_oe=1, AD_out=mem_rdata, updated every cycle from mem_addr.
  - END: DEVSEL=1, TRDY=1, AD_oe=0 for one cycle, then IDLE, or a new decode if an address phase is seen.
  - BUSY: outputs deasserted; return to IDLE at the first edge with FRAME=1 and IRDY=1.
- Transfer: an edge in WDATA or RDATA with IRDY=0 (TRDY is already 0).
  - Write: mem_we=1 combinationally in that cycle, so the memory captures on the same edge.
  - Both directions: the pointer advances on that edge, DEPTH-1 wraps to 0, matching the memory pointer.
  - IRDY=1 inserts wait states: no write, no pointer change, TRDY stays 0.
- Last transfer: a transfer with FRAME=1 moves to END on that edge.
- Master abandon: FRAME=1 and IRDY=1 in WDATA or RDATA moves to END with no transfer.
- mem_we=0 in every state other than WDATA.
- Target latency: write data transfer possible on the 2nd edge after the address phase; read data on the 3rd edge.
- frame_q and irdy_q are registered copies of FRAME and IRDY.

Decomposition:
- Shared package pci_pkg holds:
  - command constants CMD_MEM_READ=4'b0110 and CMD_MEM_WRITE=4'b0111;
  - the state enum (IDLE, WDATA, RTURN, RDATA, END, BUSY);
  - active-low level constants ASSERTED=1'b0 and DEASSERTED=1'b1.
- One natural sub-module, pci_addr_decode: purely combinational. Inputs AD_in and C_BE; outputs hit, is_write and start_ptr; parameterised by BASE_ADDR and DEPTH.

Test Plan:
1. Single write: address phase AD=0x1008, C_BE=0111, FRAME deasserted with IRDY=0 on the next cycle, data 0xDEADBEEF, C_BE=0000 -> DEVSEL=0 and TRDY=0 one cycle after the address phase; mem_we=1 for one cycle with mem_addr=2, mem_be=1111; END for one cycle, then IDLE.
2. Burst write with wrap: start AD=0x1020 (word 8), 4 data phases -> mem_addr sequence 8, 9, 0, 1; mem_we=1 for four cycles.
3. Wait states: write burst with IRDY=1 for 2 cycles mid-burst -> mem_we=0 and mem_addr held during the waits; 3 total writes at consecutive addresses.
4. Read: AD=0x1004, C_BE=0110, memory holding 0x12345678 at word 1 -> RTURN cycle with AD_oe=0, then AD_oe=1, AD_out=0x12345678; TRDY=0 only from the second cycle after the address phase.
5. Miss and unsupported command: AD=0x2000 write, and AD=0x1000 with C_BE=0010 -> DEVSEL stays 1 and mem_we stays 0 throughout; back to IDLE after FRAME=1 and IRDY=1.
6. Reset mid-burst: rst_n=0 during WDATA with IRDY=0 -> DEVSEL, TRDY and AD_oe deassert asynchronously; no further writes; pointer=0 after release.
